console_uart: RTL and testbench

Console output controller for the barbecue core. It accepts the core's `console_we`/`console_wdata` byte writes into a FIFO and serializes each byte as an 8N1 UART frame on `tx`. Synthesized builds use it in place of the simulation-only `$write` console path. It decouples single-cycle core writes from the much slower serial line.

---
 rtl/console_uart.sv | 151 +++++++++++++++
 tb/tb_console_uart.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/console_uart.sv
// Console output controller: queues core byte writes in a FIFO and sends each one
// as an 8N1 UART frame on tx, back-to-back while bytes remain queued.
module console_uart #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          console_we,
  input  logic [XLEN-1:0]               console_wdata,
  output logic                          tx,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          overflow
);

  localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned BitCntW = $clog2(CLKS_PER_BIT);

  localparam logic [BitCntW-1:0] BitLast = BitCntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0]    Depth   = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

  state_t              state;
  logic [7:0]          mem [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr;
  logic [PtrW-1:0]     rd_ptr;
  logic [7:0]          shift;
  logic [BitCntW-1:0]  bit_cnt;
  logic [2:0]          bit_idx;

  logic push;
  logic pop;
  logic fifo_empty;
  logic frame_done;

  if (XLEN > 8) begin : g_unused_upper
    logic unused_wdata;
    assign unused_wdata = ^console_wdata[XLEN-1:8];
  end

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == Depth);
  assign busy       = !fifo_empty || (state != StIdle);
  assign frame_done = (state == StStop) && (bit_cnt == BitLast);

  // A full FIFO drops the write even if a pop frees a slot in the same cycle.
  assign push = console_we && !fifo_full && !reset;
  assign pop  = !fifo_empty && ((state == StIdle) || frame_done);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= console_wdata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PtrW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CntW'(1);
        2'b01:   fifo_count <= fifo_count - CntW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (console_we && fifo_full) begin
        overflow <= 1'b1;
      end
    end
  end

  // tx is registered alongside the state so each bit level appears in the
  // first cycle of the state that owns it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= StIdle;
      tx      <= 1'b1;
      shift   <= '0;
      bit_cnt <= '0;
      bit_idx <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (pop) begin
            state   <= StStart;
            tx      <= 1'b0;
            shift   <= mem[rd_ptr];
            bit_cnt <= '0;
          end
        end
        StStart: begin
          if (bit_cnt == BitLast) begin
            state   <= StData;
            tx      <= shift[0];
            bit_cnt <= '0;
            bit_idx <= '0;
          end else begin
            bit_cnt <= bit_cnt + BitCntW'(1);
          end
        end
        StData: begin
          if (bit_cnt == BitLast) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= StStop;
              tx    <= 1'b1;
            end else begin
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            bit_cnt <= bit_cnt + BitCntW'(1);
          end
        end
        StStop: begin
          if (bit_cnt == BitLast) begin
            bit_cnt <= '0;
            if (pop) begin
              state <= StStart;
              tx    <= 1'b0;
              shift <= mem[rd_ptr];
            end else begin
              state <= StIdle;
            end
          end else begin
            bit_cnt <= bit_cnt + BitCntW'(1);
          end
        end
        default: begin
          state <= StIdle;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_console_uart.sv
// Directed bench for console_uart at CLKS_PER_BIT=4, FIFO_DEPTH=4; a background
// monitor decodes tx frames into a queue for the byte-level checks.
module tb_console_uart;

  localparam int unsigned XLEN = 32;
  localparam int unsigned CPB  = 4;
  localparam int unsigned DEP  = 4;

  logic            clk;
  logic            reset;
  logic            console_we;
  logic [XLEN-1:0] console_wdata;
  logic            tx;
  logic            fifo_full;
  logic [2:0]      fifo_count;
  logic            busy;
  logic            overflow;

  int checks   = 0;
  int failures = 0;

  console_uart #(
    .XLEN(XLEN),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .console_we(console_we),
    .console_wdata(console_wdata),
    .tx(tx),
    .fifo_full(fifo_full),
    .fifo_count(fifo_count),
    .busy(busy),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame monitor: cnt 0 is the first start cycle; samples mid-bit.
  logic [7:0] rxq[$];
  bit         mon_active = 1'b0;
  int         mon_cnt    = 0;
  int         frame_errs = 0;
  logic [7:0] mon_byte;

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == 2 && tx !== 1'b0) frame_errs++;
      if (mon_cnt >= 6 && mon_cnt <= 34 && ((mon_cnt - 6) % 4) == 0)
        mon_byte[(mon_cnt - 6) / 4] = tx;
      if (mon_cnt == 38) begin
        if (tx !== 1'b1) frame_errs++;
        rxq.push_back(mon_byte);
      end
      if (mon_cnt == 39) mon_active = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    console_we = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    rxq.delete();
  endtask

  // Expected tx at position pos (0 = first start cycle) within a frame of byte b.
  function automatic logic frame_tx(input int pos, input logic [7:0] b);
    if (pos < 4) return 1'b0;
    if (pos < 36) return b[(pos - 4) / 4];
    return 1'b1;
  endfunction

  task automatic wait_frames(input int n, input int budget);
    for (int i = 0; i < budget && rxq.size() < n; i++) tick();
    checks++;
    if (rxq.size() < n) begin
      failures++;
      $display("FAIL wait_frames: got %0d frames, expected %0d", rxq.size(), n);
    end
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    console_we    = 1'b1;
    console_wdata = 32'h0000_0011;
    tick();
    tick();
    checks += 5;
    if (tx !== 1'b1)         begin failures++; $display("FAIL reset_tx: got %b expected 1", tx); end
    if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    if (fifo_full !== 1'b0)  begin failures++; $display("FAIL reset_full: got %b expected 0", fifo_full); end
    if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (overflow !== 1'b0)   begin failures++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    reset      = 1'b0;
    console_we = 1'b0;
    tick();
    checks++;
    if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_we_ignored: got %0d expected 0", fifo_count); end
  endtask

  task automatic test_single_byte();
    logic e_tx, e_busy;
    int   e_cnt;
    do_reset();
    console_we    = 1'b1;
    console_wdata = 32'h0000_0041;
    tick();
    console_we = 1'b0;
    for (int c = 1; c <= 43; c++) begin
      e_tx   = (c < 2 || c >= 42) ? 1'b1 : frame_tx(c - 2, 8'h41);
      e_busy = (c <= 41);
      e_cnt  = (c == 1) ? 1 : 0;
      checks += 3;
      if (tx !== e_tx) begin
        failures++; $display("FAIL single_tx c%0d: got %b expected %b", c, tx, e_tx);
      end
      if (busy !== e_busy) begin
        failures++; $display("FAIL single_busy c%0d: got %b expected %b", c, busy, e_busy);
      end
      if (fifo_count !== 3'(e_cnt)) begin
        failures++; $display("FAIL single_count c%0d: got %0d expected %0d", c, fifo_count, e_cnt);
      end
      tick();
    end
    checks++;
    if (rxq.size() != 1 || rxq[0] !== 8'h41) begin
      failures++; $display("FAIL single_rx: got %0d frames, expected one 0x41", rxq.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    logic       e_tx;
    bytes[0] = 8'h55;
    bytes[1] = 8'hAA;
    bytes[2] = 8'h0F;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      console_we    = 1'b1;
      console_wdata = {24'h0, bytes[i]};
      if (i == 2) begin
        checks++;
        if (tx !== 1'b0) begin failures++; $display("FAIL b2b_start: got %b expected 0", tx); end
      end
      tick();
    end
    console_we = 1'b0;
    for (int c = 3; c <= 123; c++) begin
      e_tx = (c >= 122) ? 1'b1 : frame_tx((c - 2) % 40, bytes[(c - 2) / 40]);
      checks += 2;
      if (tx !== e_tx) begin
        failures++; $display("FAIL b2b_tx c%0d: got %b expected %b", c, tx, e_tx);
      end
      if (busy !== (c <= 121)) begin
        failures++; $display("FAIL b2b_busy c%0d: got %b expected %b", c, busy, (c <= 121));
      end
      tick();
    end
    checks++;
    if (rxq.size() != 3) begin
      failures++; $display("FAIL b2b_count: got %0d frames expected 3", rxq.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rxq[i] !== bytes[i]) begin
          failures++; $display("FAIL b2b_byte%0d: got %h expected %h", i, rxq[i], bytes[i]);
        end
      end
    end
  endtask

  task automatic test_upper_bits();
    do_reset();
    console_we    = 1'b1;
    console_wdata = 32'hDEAD_BE55;
    tick();
    console_we = 1'b0;
    wait_frames(1, 100);
    checks++;
    if (rxq.size() < 1 || rxq[0] !== 8'h55) begin
      failures++; $display("FAIL upper_bits: got %h expected 55", (rxq.size() > 0) ? rxq[0] : 8'hxx);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      console_we    = 1'b1;
      console_wdata = 32'(i);
      if (i == 5) begin
        checks += 3;
        if (fifo_full !== 1'b1)  begin failures++; $display("FAIL ovf_full: got %b expected 1", fifo_full); end
        if (fifo_count !== 3'd4) begin failures++; $display("FAIL ovf_count: got %0d expected 4", fifo_count); end
        if (overflow !== 1'b0)   begin failures++; $display("FAIL ovf_early: got %b expected 0", overflow); end
      end
      tick();
    end
    console_we = 1'b0;
    checks += 2;
    if (overflow !== 1'b1)   begin failures++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    if (fifo_count !== 3'd4) begin failures++; $display("FAIL ovf_dropped: got %0d expected 4", fifo_count); end
    wait_frames(5, 400);
    for (int i = 0; i < 5 && i < rxq.size(); i++) begin
      checks++;
      if (rxq[i] !== 8'(i)) begin
        failures++; $display("FAIL ovf_byte%0d: got %h expected %h", i, rxq[i], 8'(i));
      end
    end
    for (int i = 0; i < 100 && busy; i++) tick();
    for (int i = 0; i < 60; i++) tick();
    checks += 3;
    if (rxq.size() != 5)   begin failures++; $display("FAIL ovf_frames: got %0d expected 5", rxq.size()); end
    if (busy !== 1'b0)     begin failures++; $display("FAIL ovf_idle: got %b expected 0", busy); end
    if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
  endtask

  // Runs right after test_overflow so overflow is still set going in.
  task automatic test_reset_mid_frame();
    rxq.delete();
    for (int i = 0; i < 4; i++) begin
      console_we    = 1'b1;
      console_wdata = 32'h11 * (i + 1);
      tick();
    end
    console_we = 1'b0;
    for (int c = 4; c < 15; c++) tick();
    checks += 2;
    if (fifo_count !== 3'd3) begin failures++; $display("FAIL mid_queued: got %0d expected 3", fifo_count); end
    if (overflow !== 1'b1)   begin failures++; $display("FAIL mid_pre_ovf: got %b expected 1", overflow); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks += 5;
    if (tx !== 1'b1)         begin failures++; $display("FAIL mid_tx: got %b expected 1", tx); end
    if (fifo_count !== 3'd0) begin failures++; $display("FAIL mid_count: got %0d expected 0", fifo_count); end
    if (busy !== 1'b0)       begin failures++; $display("FAIL mid_busy: got %b expected 0", busy); end
    if (overflow !== 1'b0)   begin failures++; $display("FAIL mid_overflow: got %b expected 0", overflow); end
    if (fifo_full !== 1'b0)  begin failures++; $display("FAIL mid_full: got %b expected 0", fifo_full); end
    for (int i = 0; i < 150; i++) tick();
    checks += 2;
    if (rxq.size() != 0) begin failures++; $display("FAIL mid_no_frames: got %0d expected 0", rxq.size()); end
    if (busy !== 1'b0)   begin failures++; $display("FAIL mid_stays_idle: got %b expected 0", busy); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_b [10];
    int         max_cnt = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      exp_b[i]      = 8'h30 + 8'(i * 13);
      console_we    = 1'b1;
      console_wdata = {24'h0, exp_b[i]};
      for (int c = 0; c < 40; c++) begin
        if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
        tick();
        console_we = 1'b0;
      end
    end
    wait_frames(10, 100);
    for (int i = 0; i < 10 && i < rxq.size(); i++) begin
      checks++;
      if (rxq[i] !== exp_b[i]) begin
        failures++; $display("FAIL wrap_byte%0d: got %h expected %h", i, rxq[i], exp_b[i]);
      end
    end
    checks++;
    if (max_cnt > 1) begin failures++; $display("FAIL wrap_max_count: got %0d expected <=1", max_cnt); end
  endtask

  initial begin
    reset         = 1'b1;
    console_we    = 1'b0;
    console_wdata = '0;
    tick();
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_upper_bits();
    test_overflow();
    test_reset_mid_frame();
    test_wrap();
    checks++;
    if (frame_errs != 0) begin failures++; $display("FAIL framing: got %0d errors expected 0", frame_errs); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
